delay_sequencer: RTL and testbench

Sequencer that drives the `delay_i` input of the decimate-and-delay datapath. It accepts target delays over a valid/ready handshake, clamps them to the legal range, and ramps the applied delay toward the target in bounded steps. Each step is taken only on a decimated-sample strobe, so the delay line never jumps by more than `STEP_SIZE` samples at once. After reaching the target it waits a programmable number of decimated samples, then reports settled to the register/control layer.

---
 rtl/delay_sequencer_pkg.sv | 13 +
 rtl/delay_stepper.sv | 39 +++
 rtl/delay_sequencer.sv | 128 ++++++++++++
 tb/tb_delay_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/delay_sequencer_pkg.sv
// Shared types and constants for the delay sequencer.
// Build option DELAY_SEQUENCER_RAMP_EN selects stepped ramping in delay_stepper.
package delay_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } dseq_state_t;

  localparam int DSEQ_CNT_W = 8;

endpackage

// File: rtl/delay_stepper.sv
// Combinational next-delay computation for the delay sequencer.
// DELAY_SEQUENCER_RAMP_EN defined: step by at most STEP_SIZE; undefined: jump straight to target.
module delay_stepper #(
  parameter int W         = 15,
  parameter int STEP_SIZE = 16
) (
  input  logic [W-1:0] cur_delay,
  input  logic [W-1:0] target,
  output logic [W-1:0] next_delay,
  output logic         at_target
);

`ifdef DELAY_SEQUENCER_RAMP_EN
  localparam logic signed [W:0] STEP_POS = (W+1)'(STEP_SIZE);
  localparam logic signed [W:0] STEP_NEG = -STEP_POS;

  logic signed [W:0] diff;

  // One extra bit keeps the signed difference exact across the full unsigned range.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, cur_delay});
    if (diff > STEP_POS) begin
      next_delay = cur_delay + W'(STEP_SIZE);
    end else if (diff < STEP_NEG) begin
      next_delay = cur_delay - W'(STEP_SIZE);
    end else begin
      next_delay = target;
    end
    at_target = (next_delay == target);
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{cur_delay, 32'(STEP_SIZE)};
  assign next_delay    = target;
  assign at_target     = 1'b1;
`endif

endmodule

// File: rtl/delay_sequencer.sv
// Ramps the datapath delay toward accepted targets on sample strobes, then reports settled.
// Ramp shape is chosen by DELAY_SEQUENCER_RAMP_EN (see delay_stepper).
import delay_sequencer_pkg::*;

module delay_sequencer #(
  parameter int LOG2_MAX_DELAY = 15,
  parameter int MIN_DELAY      = 1,
  parameter int RESET_DELAY    = 1,
  parameter int STEP_SIZE      = 16,
  parameter int SETTLE_SAMPLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [LOG2_MAX_DELAY-1:0] target_i,
  input  logic                      target_valid_i,
  output logic                      target_ready_o,
  input  logic                      sample_valid_i,
  output logic [LOG2_MAX_DELAY-1:0] delay_o,
  output logic                      busy_o,
  output logic                      settled_o,
  output logic                      clamped_o
);

  localparam int W = LOG2_MAX_DELAY;
  localparam logic [W-1:0]          MIN_D    = W'(MIN_DELAY);
  localparam logic [W-1:0]          RESET_D  = W'(RESET_DELAY);
  localparam logic [DSEQ_CNT_W-1:0] SETTLE_N = DSEQ_CNT_W'(SETTLE_SAMPLES);

  dseq_state_t           state_q, state_d;
  logic [W-1:0]          delay_q, delay_d;
  logic [W-1:0]          target_q, target_d;
  logic [DSEQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                  settled_q, settled_d;
  logic                  busy_q, clamped_q;

  logic                  accept;
  logic                  below_min;
  logic [W-1:0]          target_c;
  logic [W-1:0]          step_next;
  logic                  step_at_target;

  assign target_ready_o = !rst_i && (state_q != RAMP);
  assign accept         = target_valid_i && target_ready_o;
  assign below_min      = (target_i < MIN_D);
  assign target_c       = below_min ? MIN_D : target_i;

  delay_stepper #(
    .W         (W),
    .STEP_SIZE (STEP_SIZE)
  ) u_stepper (
    .cur_delay  (delay_q),
    .target     (target_q),
    .next_delay (step_next),
    .at_target  (step_at_target)
  );

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    case (state_q)
      IDLE: begin
        if (accept && (target_c != delay_q)) begin
          target_d  = target_c;
          settled_d = 1'b0;
          state_d   = RAMP;
        end
      end
      RAMP: begin
        if (sample_valid_i) begin
          delay_d = step_next;
          if (step_at_target) begin
            cnt_d   = SETTLE_N;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // A new target takes priority over a coincident strobe.
        if (accept) begin
          if (target_c != delay_q) begin
            target_d = target_c;
            state_d  = RAMP;
          end else begin
            cnt_d = SETTLE_N;
          end
        end else if (sample_valid_i) begin
          if (cnt_q <= DSEQ_CNT_W'(1)) begin
            cnt_d     = '0;
            settled_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - DSEQ_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      delay_q   <= RESET_D;
      target_q  <= RESET_D;
      cnt_q     <= '0;
      settled_q <= 1'b1;
      busy_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      busy_q    <= (state_d != IDLE);
      clamped_q <= accept && below_min;
    end
  end

  assign delay_o   = delay_q;
  assign busy_o    = busy_q;
  assign settled_o = settled_q;
  assign clamped_o = clamped_q;

endmodule

// File: tb/tb_delay_sequencer.sv
// Directed self-checking bench for delay_sequencer; expectations follow DELAY_SEQUENCER_RAMP_EN.
module tb_delay_sequencer;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] target = '0;
  logic         target_valid = 1'b0;
  logic         target_ready;
  logic         sample_valid = 1'b0;
  logic [W-1:0] delay;
  logic         busy;
  logic         settled;
  logic         clamped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_sequencer #(
    .LOG2_MAX_DELAY (W),
    .MIN_DELAY      (1),
    .RESET_DELAY    (1),
    .STEP_SIZE      (16),
    .SETTLE_SAMPLES (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .target_i       (target),
    .target_valid_i (target_valid),
    .target_ready_o (target_ready),
    .sample_valid_i (sample_valid),
    .delay_o        (delay),
    .busy_o         (busy),
    .settled_o      (settled),
    .clamped_o      (clamped)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    repeat (31) tick();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send(input int t);
    target       = W'(t);
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_eq("ready_in_reset", int'(target_ready), 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic settle_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      strobe();
      check_eq({tag, "_settling"}, int'(settled), 0);
    end
    strobe();
    check_eq({tag, "_settled"}, int'(settled), 1);
    check_eq({tag, "_idle"}, int'(busy), 0);
  endtask

  int up_seq[$];
  int down_seq[$];
  int over_seq[$];
  int big_first;

  initial begin
`ifdef DELAY_SEQUENCER_RAMP_EN
    up_seq    = '{17, 33, 49, 50};
    down_seq  = '{34, 20};
    over_seq  = '{36, 52, 68, 84, 100};
    big_first = 17;
`else
    up_seq    = '{50};
    down_seq  = '{20};
    over_seq  = '{100};
    big_first = 32767;
`endif

    // 1. Reset
    do_reset();
    check_eq("rst_delay", int'(delay), 1);
    check_eq("rst_settled", int'(settled), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(target_ready), 1);
    check_eq("rst_clamped", int'(clamped), 0);

    // 2. Upward ramp to 50
    send(50);
    check_eq("up_busy", int'(busy), 1);
    check_eq("up_ready", int'(target_ready), 0);
    check_eq("up_settled_clr", int'(settled), 0);
    check_eq("up_hold", int'(delay), 1);
    foreach (up_seq[i]) begin
      strobe();
      check_eq("up_delay", int'(delay), up_seq[i]);
      check_eq("up_ready_step", int'(target_ready), (i == up_seq.size() - 1) ? 1 : 0);
    end
    settle_check("up");

    // 3. Downward ramp, then overlapping target with coincident strobe
    send(20);
    foreach (down_seq[i]) begin
      strobe();
      check_eq("down_delay", int'(delay), down_seq[i]);
    end
    strobe();
    check_eq("down_mid_settle", int'(settled), 0);
    repeat (31) tick();
    sample_valid = 1'b1;
    target       = W'(100);
    target_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    target_valid = 1'b0;
    check_eq("over_no_step", int'(delay), 20);
    check_eq("over_ramp_ready", int'(target_ready), 0);
    check_eq("over_busy", int'(busy), 1);
    foreach (over_seq[i]) begin
      strobe();
      check_eq("over_delay", int'(delay), over_seq[i]);
    end
    // Equal target inside SETTLE restarts the full settle count
    strobe();
    strobe();
    send(100);
    check_eq("restart_busy", int'(busy), 1);
    check_eq("restart_delay", int'(delay), 100);
    settle_check("restart");

    // 4. Clamp and equal target from delay 1
    do_reset();
    send(0);
    check_eq("clamp_pulse", int'(clamped), 1);
    check_eq("clamp_busy", int'(busy), 0);
    check_eq("clamp_delay", int'(delay), 1);
    check_eq("clamp_settled", int'(settled), 1);
    tick();
    check_eq("clamp_pulse_end", int'(clamped), 0);
    send(1);
    check_eq("equal_busy", int'(busy), 0);
    check_eq("equal_clamped", int'(clamped), 0);
    check_eq("equal_settled", int'(settled), 1);

    // 5. Strobe gap, then reset mid-ramp
    send(32767);
    repeat (1000) tick();
    check_eq("gap_delay", int'(delay), 1);
    check_eq("gap_busy", int'(busy), 1);
    strobe();
    check_eq("gap_first_step", int'(delay), big_first);
    rst = 1'b1;
    tick();
    check_eq("midrst_delay", int'(delay), 1);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_settled", int'(settled), 1);
    check_eq("midrst_ready", int'(target_ready), 0);
    rst = 1'b0;
    tick();
    check_eq("midrst_ready_after", int'(target_ready), 1);
    check_eq("midrst_hold", int'(delay), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
